// File: rtl/aibcr3_data_buf_pipe.sv
// Multi-lane data buffer with run-time selectable latency (0 = combinational pass-through,
// 1..MAX_DEPTH = valid-qualified register pipeline), lane masking, flush and settle tracking.
module aibcr3_data_buf_pipe #(
    parameter  int WIDTH     = 2,
    parameter  int LANES     = 4,
    parameter  int MAX_DEPTH = 4,
    localparam int LW        = $clog2(MAX_DEPTH + 1),
    localparam int DW        = LANES * WIDTH
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic [LW-1:0] cfg_lat_sel,
    input  logic [LANES-1:0] cfg_lane_en,
    input  logic          flush,
    input  logic          sig_in_vld,
    input  logic [DW-1:0] sig_in,
    output logic          sig_out_vld,
    output logic [DW-1:0] sig_out,
    output logic          lat_chg_busy
);

    logic [DW-1:0]        stg_data_q [1:MAX_DEPTH];
    logic [DW-1:0]        stg_data_d [1:MAX_DEPTH];
    logic [MAX_DEPTH:1]   stg_vld_q;
    logic [MAX_DEPTH:1]   stg_vld_d;
    logic [LW-1:0]        lat_q;
    logic [LW-1:0]        lat_d;
    logic [LW-1:0]        settle_q;
    logic [LW-1:0]        settle_d;

    logic [LW-1:0]        lat_clamp_s;
    logic                 lat_chg_s;
    logic                 busy_s;
    logic [DW-1:0]        sel_data_s;
    logic                 sel_vld_s;

    // Next-state: clamp the request, shift the pipeline, drop valids on flush or latency change.
    always_comb begin
        lat_clamp_s = (cfg_lat_sel > LW'(MAX_DEPTH)) ? LW'(MAX_DEPTH) : cfg_lat_sel;
        lat_chg_s   = (lat_clamp_s != lat_q);
        lat_d       = lat_clamp_s;

        stg_data_d[1] = sig_in;
        for (int k = 2; k <= MAX_DEPTH; k++) begin
            stg_data_d[k] = stg_data_q[k-1];
        end

        if (flush || lat_chg_s) begin
            stg_vld_d = '0;
        end else begin
            stg_vld_d[1] = sig_in_vld;
            for (int k = 2; k <= MAX_DEPTH; k++) begin
                stg_vld_d[k] = stg_vld_q[k-1];
            end
        end

        if (lat_chg_s) begin
            settle_d = lat_clamp_s;
        end else if (settle_q != '0) begin
            settle_d = settle_q - LW'(1);
        end else begin
            settle_d = settle_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                stg_data_q[k] <= '0;
            end
            stg_vld_q <= '0;
            lat_q     <= '0;
            settle_q  <= '0;
        end else begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                stg_data_q[k] <= stg_data_d[k];
            end
            stg_vld_q <= stg_vld_d;
            lat_q     <= lat_d;
            settle_q  <= settle_d;
        end
    end

    // Output select by latency, then lane mask; reset gates everything to zero.
    always_comb begin
        busy_s     = (settle_q != '0);
        sel_data_s = '0;
        sel_vld_s  = 1'b0;
        if (lat_q == '0) begin
            sel_data_s = sig_in;
            sel_vld_s  = sig_in_vld & ~flush & ~busy_s;
        end else begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                if (lat_q == LW'(k)) begin
                    sel_data_s = stg_data_q[k];
                    sel_vld_s  = stg_vld_q[k] & ~busy_s;
                end else begin
                    sel_data_s = sel_data_s;
                end
            end
        end

        sig_out      = '0;
        sig_out_vld  = 1'b0;
        lat_chg_busy = 1'b0;
        if (rstb) begin
            for (int k = 0; k < LANES; k++) begin
                sig_out[k*WIDTH +: WIDTH] = cfg_lane_en[k] ? sel_data_s[k*WIDTH +: WIDTH]
                                                           : {WIDTH{1'b0}};
            end
            sig_out_vld  = sel_vld_s;
            lat_chg_busy = busy_s;
        end else begin
            sig_out_vld = 1'b0;
        end
    end

endmodule

// File: tb/tb_aibcr3_data_buf_pipe.sv
// Scoreboard bench: stimulus pushes {expected cycle, expected data}; a negedge monitor pops on valid.
module tb_aibcr3_data_buf_pipe;

    logic       clk = 1'b0;
    logic       rstb;
    logic [2:0] cfg_lat_sel;
    logic [3:0] cfg_lane_en;
    logic       flush;
    logic       sig_in_vld;
    logic [7:0] sig_in;
    logic       sig_out_vld;
    logic [7:0] sig_out;
    logic       lat_chg_busy;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    aibcr3_data_buf_pipe #(.WIDTH(2), .LANES(4), .MAX_DEPTH(4)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .cfg_lat_sel  (cfg_lat_sel),
        .cfg_lane_en  (cfg_lane_en),
        .flush        (flush),
        .sig_in_vld   (sig_in_vld),
        .sig_in       (sig_in),
        .sig_out_vld  (sig_out_vld),
        .sig_out      (sig_out),
        .lat_chg_busy (lat_chg_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input int dly);
        exp_q.push_back({32'(cyc + dly), d});
    endtask

    // Request a new latency and check the busy window length.
    task automatic set_lat(input logic [2:0] l, input int busy_n);
        cfg_lat_sel = l;
        sig_in_vld  = 1'b0;
        tick();
        for (int i = 0; i < busy_n; i++) begin
            @(negedge clk);
            chk("busy_high", lat_chg_busy, 1);
            tick();
        end
        @(negedge clk);
        chk("busy_low", lat_chg_busy, 0);
        tick();
    endtask

    // Monitor: every valid output must match the head of the scoreboard, at the right cycle.
    always @(negedge clk) begin
        if ($isunknown(sig_out_vld)) begin
            total++;
            bad++;
            $display("FAIL vld_unknown: got %b want 0/1 (cycle %0d)", sig_out_vld, cyc);
        end else if (sig_out_vld) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_vld: got data %0h at cycle %0d want no valid", sig_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", sig_out, mon_e.data);
                chk("out_cycle", cyc, mon_e.cyc);
            end
            chk("vld_during_busy", lat_chg_busy, 0);
        end
    end

    initial begin
        rstb        = 1'b0;
        flush       = 1'b0;
        sig_in      = 8'hFF;
        sig_in_vld  = 1'b1;
        cfg_lat_sel = 3'd0;
        cfg_lane_en = 4'hF;

        // T1 reset: outputs gated, then pass-through at latency 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out", sig_out, 0);
            chk("rst_vld", sig_out_vld, 0);
            chk("rst_busy", lat_chg_busy, 0);
            tick();
        end
        rstb   = 1'b1;
        sig_in = 8'h5A;
        push(8'h5A, 0);
        @(negedge clk);
        chk("post_rst_busy", lat_chg_busy, 0);
        tick();
        sig_in = 8'h3C;
        push(8'h3C, 0);
        tick();
        sig_in_vld = 1'b0;
        tick();

        // T2 latency sweep
        for (int l = 1; l <= 4; l++) begin
            set_lat(3'(l), l);
            sig_in     = 8'hA5;
            sig_in_vld = 1'b1;
            push(8'hA5, l);
            tick();
            sig_in_vld = 1'b0;
            repeat (l + 1) tick();
        end

        // T3 flush at latency 3: flush lands on the edge that would capture 8'h33
        set_lat(3'd3, 3);
        sig_in = 8'h11; sig_in_vld = 1'b1;
        tick();
        sig_in = 8'h22;
        tick();
        sig_in = 8'h33; flush = 1'b1;
        tick();
        flush  = 1'b0;
        sig_in = 8'h44;
        push(8'h44, 3);
        tick();
        sig_in_vld = 1'b0;
        repeat (4) tick();

        // T4 latency change 2 -> 4 mid-stream, then 4 -> 0
        set_lat(3'd2, 2);
        sig_in = 8'h61; sig_in_vld = 1'b1;
        push(8'h61, 2);
        tick();
        sig_in = 8'h62;
        tick();
        sig_in = 8'h63; cfg_lat_sel = 3'd4;
        tick();
        sig_in = 8'h64;
        push(8'h64, 4);
        @(negedge clk);
        chk("chg_busy", lat_chg_busy, 1);
        tick();
        sig_in_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("chg_busy", lat_chg_busy, 1);
            tick();
        end
        @(negedge clk);
        chk("chg_busy_end", lat_chg_busy, 0);
        tick();
        cfg_lat_sel = 3'd0;
        sig_in = 8'h70; sig_in_vld = 1'b1;
        tick();
        sig_in = 8'h77;
        push(8'h77, 0);
        @(negedge clk);
        chk("to_zero_busy", lat_chg_busy, 0);
        tick();
        sig_in_vld = 1'b0;
        tick();

        // T5 lane mask at latency 1, toggled while a beat is on the output
        set_lat(3'd1, 1);
        cfg_lane_en = 4'b0101;
        sig_in = 8'hFF; sig_in_vld = 1'b1;
        push(8'h33, 1);
        tick();
        push(8'hCC, 1);
        tick();
        cfg_lane_en = 4'b1010;
        sig_in_vld  = 1'b0;
        tick();
        cfg_lane_en = 4'hF;
        tick();

        // T6 clamp: 7 behaves as 4, and re-requesting 4 is not a change
        set_lat(3'd7, 4);
        sig_in = 8'h9C; sig_in_vld = 1'b1;
        push(8'h9C, 4);
        tick();
        sig_in_vld = 1'b0;
        repeat (5) tick();
        cfg_lat_sel = 3'd4;
        tick();
        @(negedge clk);
        chk("clamp_same_busy", lat_chg_busy, 0);
        tick();

        // T6 overlap: reset dominates flush and latency change
        sig_in = 8'h5E; sig_in_vld = 1'b1;
        tick();
        flush = 1'b1; cfg_lat_sel = 3'd2; rstb = 1'b0; sig_in = 8'hFF;
        @(negedge clk);
        chk("ovl_out", sig_out, 0);
        chk("ovl_vld", sig_out_vld, 0);
        chk("ovl_busy", lat_chg_busy, 0);
        tick();
        rstb = 1'b1; flush = 1'b0; cfg_lat_sel = 3'd0;
        sig_in = 8'h81;
        push(8'h81, 0);
        @(negedge clk);
        chk("ovl_post_busy", lat_chg_busy, 0);
        tick();
        sig_in_vld = 1'b0;
        repeat (6) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
